// File: rtl/branch_sequencer_pkg.sv
// Shared types and constants for the conditional-branch sequencer slice.
package branch_sequencer_pkg;

  localparam int unsigned PC_W_DEF  = 32;
  localparam int unsigned IMM_W_DEF = 19;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_EVAL   = 3'd1,
    ST_HOLD   = 3'd2,
    ST_ADD    = 3'd3,
    ST_COMMIT = 3'd4
  } state_t;

  localparam logic [1:0] COND_ZR = 2'b00;
  localparam logic [1:0] COND_NZ = 2'b01;
  localparam logic [1:0] COND_PL = 2'b10;
  localparam logic [1:0] COND_MI = 2'b11;

endpackage

// File: rtl/branch_sequencer_pc_reg.sv
// Program counter register: synchronous active-low clear, increment, target load.
module pc_reg #(
  parameter int unsigned     PC_W     = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            clr_n,
  input  logic            inc,
  input  logic            load,
  input  logic [PC_W-1:0] target,
  output logic [PC_W-1:0] pc
);

  always_ff @(posedge clk) begin
    if (!clr_n)
      pc <= RESET_PC;
    else if (load)
      pc <= target;
    else if (inc)
      pc <= pc + {{(PC_W-1){1'b0}}, 1'b1};
  end

endmodule

// File: rtl/branch_sequencer.sv
// Sequences brzr/brnz/brpl/brmi through EVAL/HOLD/ADD/COMMIT and owns the PC.
module branch_sequencer
  import branch_sequencer_pkg::*;
#(
  parameter int unsigned     PC_W     = PC_W_DEF,
  parameter int unsigned     IMM_W    = IMM_W_DEF,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             start,
  input  logic [1:0]       cond,
  input  logic [IMM_W-1:0] imm,
  input  logic             pc_inc,
  input  logic             con_out,
  output logic [1:0]       cond_sel,
  output logic             gra_out,
  output logic             con_in,
  output logic             busy,
  output logic             done,
  output logic             taken,
  output logic [PC_W-1:0]  pc
);

  state_t           state;
  logic [IMM_W-1:0] imm_r;
  logic [PC_W-1:0]  target_r;
  logic [PC_W-1:0]  imm_ext;
  logic             pc_step;
  logic             pc_load;

  assign imm_ext = {{(PC_W-IMM_W){imm_r[IMM_W-1]}}, imm_r};
  // start has priority over a same-cycle fetch increment
  assign pc_step = (state == ST_IDLE) && !start && pc_inc;
  assign pc_load = (state == ST_COMMIT) && taken;

  pc_reg #(
    .PC_W     (PC_W),
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk    (clk),
    .clr_n  (clr_n),
    .inc    (pc_step),
    .load   (pc_load),
    .target (target_r),
    .pc     (pc)
  );

  // Outputs are set on entry to each state so they are registered, not decoded.
  always_ff @(posedge clk) begin
    if (!clr_n) begin
      state    <= ST_IDLE;
      cond_sel <= '0;
      imm_r    <= '0;
      target_r <= '0;
      gra_out  <= 1'b0;
      con_in   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      taken    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            cond_sel <= cond;
            imm_r    <= imm;
            gra_out  <= 1'b1;
            con_in   <= 1'b1;
            busy     <= 1'b1;
            state    <= ST_EVAL;
          end
        end
        ST_EVAL: begin
          con_in <= 1'b0;
          state  <= ST_HOLD;
        end
        ST_HOLD: begin
          gra_out <= 1'b0;
          state   <= ST_ADD;
        end
        ST_ADD: begin
          target_r <= pc + imm_ext;
          taken    <= con_out;
          done     <= 1'b1;
          state    <= ST_COMMIT;
        end
        ST_COMMIT: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          gra_out <= 1'b0;
          con_in  <= 1'b0;
          busy    <= 1'b0;
          done    <= 1'b0;
          state   <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_branch_sequencer.sv
// Scoreboard bench: stimulus pushes expected branch results, a monitor checks them on done.
module tb_branch_sequencer;
  import branch_sequencer_pkg::*;

  logic        clk;
  logic        clr_n;
  logic        start;
  logic [1:0]  cond;
  logic [18:0] imm;
  logic        pc_inc;
  logic        con_out;
  logic [1:0]  cond_sel;
  logic        gra_out;
  logic        con_in;
  logic        busy;
  logic        done;
  logic        taken;
  logic [31:0] pc;

  typedef struct {
    logic        taken;
    logic [31:0] pc;
    logic [1:0]  cond;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          failures = 0;
  bit          pc_pending = 0;
  logic [31:0] pc_expected;

  branch_sequencer #(
    .PC_W     (32),
    .IMM_W    (19),
    .RESET_PC (32'h0000_0000)
  ) dut (
    .clk      (clk),
    .clr_n    (clr_n),
    .start    (start),
    .cond     (cond),
    .imm      (imm),
    .pc_inc   (pc_inc),
    .con_out  (con_out),
    .cond_sel (cond_sel),
    .gra_out  (gra_out),
    .con_in   (con_in),
    .busy     (busy),
    .done     (done),
    .taken    (taken),
    .pc       (pc)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Monitor: pc is checked the cycle after done, when the commit is visible.
  always @(negedge clk) begin
    if (pc_pending) begin
      chk("sb_pc", pc, pc_expected);
      pc_pending = 0;
    end
    if (done) begin
      if (sb.size() == 0) begin
        chk("sb_unexpected_done", {31'b0, done}, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("sb_taken", {31'b0, taken}, {31'b0, e.taken});
        chk("sb_cond_sel", {30'b0, cond_sel}, {30'b0, e.cond});
        chk("sb_busy_in_commit", {31'b0, busy}, 32'd1);
        pc_expected = e.pc;
        pc_pending  = 1;
      end
    end
  end

  task automatic branch(input logic [1:0] c, input logic [18:0] i, input logic flag,
                        input logic inc_with_start, input logic disturb,
                        input logic [31:0] exp_pc);
    exp_t e;
    e.taken = flag;
    e.pc    = exp_pc;
    e.cond  = c;
    sb.push_back(e);
    cond = c; imm = i; con_out = flag; start = 1'b1; pc_inc = inc_with_start;
    tick;  // cycle k+1 (EVAL)
    start = 1'b0; pc_inc = 1'b0; cond = ~c; imm = ~i;
    chk("con_in_k1", {31'b0, con_in}, 32'd1);
    chk("gra_out_k1", {31'b0, gra_out}, 32'd1);
    chk("busy_k1", {31'b0, busy}, 32'd1);
    if (disturb) begin
      start = 1'b1; pc_inc = 1'b1;
    end
    tick;  // k+2 (HOLD)
    chk("con_in_k2", {31'b0, con_in}, 32'd0);
    chk("gra_out_k2", {31'b0, gra_out}, 32'd1);
    tick;  // k+3 (ADD)
    chk("gra_out_k3", {31'b0, gra_out}, 32'd0);
    chk("con_in_k3", {31'b0, con_in}, 32'd0);
    chk("done_k3", {31'b0, done}, 32'd0);
    start = 1'b0; pc_inc = 1'b0;
    tick;  // k+4 (COMMIT)
    tick;  // k+5
  endtask

  initial begin
    clr_n = 1'b0; start = 1'b1; pc_inc = 1'b1; cond = '0; imm = '0; con_out = 1'b0;
    tick; tick;
    chk("rst_pc", pc, 32'h0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_con_in", {31'b0, con_in}, 32'd0);
    chk("rst_gra_out", {31'b0, gra_out}, 32'd0);
    chk("rst_taken", {31'b0, taken}, 32'd0);
    clr_n = 1'b1; start = 1'b0; pc_inc = 1'b0;
    repeat (3) begin
      pc_inc = 1'b1; tick; pc_inc = 1'b0; tick;
    end
    chk("inc_pc3", pc, 32'h3);
    pc_inc = 1'b1; repeat (13) tick; pc_inc = 1'b0;
    chk("inc_pc10", pc, 32'h10);

    branch(COND_NZ, 19'h00020, 1'b0, 1'b0, 1'b0, 32'h10);
    branch(COND_ZR, 19'h00008, 1'b1, 1'b0, 1'b0, 32'h18);

    clr_n = 1'b0; tick; clr_n = 1'b1;
    pc_inc = 1'b1; repeat (4) tick; pc_inc = 1'b0;
    chk("inc_pc4", pc, 32'h4);
    branch(COND_MI, 19'h7FFFC, 1'b1, 1'b0, 1'b0, 32'h0);
    branch(COND_PL, 19'h7FFFF, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFFF);

    // start+pc_inc together, then start/pc_inc/cond disturbed while busy
    branch(COND_PL, 19'h00001, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFF);
    chk("taken_hold", {31'b0, taken}, 32'd0);

    // reset during HOLD aborts without a done pulse
    cond = COND_ZR; imm = 19'h00010; con_out = 1'b1; start = 1'b1;
    tick;
    start = 1'b0;
    tick;
    chk("abort_in_hold", {31'b0, gra_out & ~con_in}, 32'd1);
    clr_n = 1'b0;
    tick;
    clr_n = 1'b1;
    chk("abort_busy", {31'b0, busy}, 32'd0);
    chk("abort_pc", pc, 32'h0);
    chk("abort_gra_out", {31'b0, gra_out}, 32'd0);
    repeat (4) begin
      tick;
      chk("abort_no_done", {31'b0, done}, 32'd0);
    end

    branch(COND_MI, 19'h00000, 1'b1, 1'b0, 1'b0, 32'h0);

    repeat (5) tick;
    chk("sb_drained", sb.size(), 32'd0);
    chk("pc_pending_clear", {31'b0, pc_pending}, 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
